// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Bundles the opcode/flag/handshake inputs and all datapath
//               control outputs of the multicycle controller. The master
//               modport is the controller, the slave modport the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if #(
  parameter int OPC_W   = 6,
  parameter int ALUOP_W = 3
);
  // Datapath to controller
  logic [OPC_W-1:0]   opcode;
  logic               zero;
  logic               mem_ready;

  // Controller to datapath
  logic               pc_write;
  logic               pc_write_cond;
  logic [1:0]         pc_src;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               reg_write;
  logic [1:0]         reg_dst;
  logic [1:0]         write_dst;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               instr_done;
  logic               illegal_op;
  logic               halted;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, write_dst, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, halted
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
           ir_write, reg_write, reg_dst, write_dst, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, halted
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle MIPS main controller. Sequences each instruction
//               through a per-opcode state machine so a single memory and a
//               single ALU are shared across cycles; memory latency is
//               absorbed by waiting on mem_ready in FETCH/MEM_RD/MEM_WR.
//               Optional performance counters are built when the macro
//               MULTICYCLE_CONTROLLER_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int OPC_W        = 6,
  parameter int ALUOP_W      = 3,
  parameter int ILLEGAL_TRAP = 0,
  parameter int CNT_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]       instr_count,
  output logic [CNT_W-1:0]       stall_count
`endif
);

  // Opcode encodings
  localparam logic [OPC_W-1:0] c_op_r    = OPC_W'(0);
  localparam logic [OPC_W-1:0] c_op_addi = OPC_W'(1);
  localparam logic [OPC_W-1:0] c_op_slti = OPC_W'(2);
  localparam logic [OPC_W-1:0] c_op_lw   = OPC_W'(3);
  localparam logic [OPC_W-1:0] c_op_sw   = OPC_W'(4);
  localparam logic [OPC_W-1:0] c_op_beq  = OPC_W'(5);
  localparam logic [OPC_W-1:0] c_op_j    = OPC_W'(6);
  localparam logic [OPC_W-1:0] c_op_jr   = OPC_W'(7);
  localparam logic [OPC_W-1:0] c_op_jal  = OPC_W'(8);

  // ALU operation codes
  localparam logic [ALUOP_W-1:0] c_alu_add   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] c_alu_sub   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] c_alu_slt   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] c_alu_funct = ALUOP_W'(3'b101);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_WB_R   = 4'd3,
    S_EXEC_I = 4'd4,
    S_WB_I   = 4'd5,
    S_ADDR   = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_LW  = 4'd8,
    S_MEM_WR = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12,
    S_JAL    = 4'd13,
    S_HALT   = 4'd14
  } state_t;

  // Where an unrecognised opcode goes after DECODE.
  localparam state_t c_illegal_next = (ILLEGAL_TRAP != 0) ? S_HALT : S_FETCH;

  state_t state_q, state_d;

  // Unsigned compare also rejects any opcode with a nonzero upper bit.
  logic w_op_legal;
  assign w_op_legal = (bus.opcode <= c_op_jal);

  logic               w_pc_write;
  logic               w_pc_write_cond;
  logic [1:0]         w_pc_src;
  logic               w_i_or_d;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_ir_write;
  logic               w_reg_write;
  logic [1:0]         w_reg_dst;
  logic [1:0]         w_write_dst;
  logic               w_alu_src_a;
  logic [1:0]         w_alu_src_b;
  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_instr_done;
  logic               w_illegal_op;
  logic               w_halted;

  // State register; reset always lands in FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection per instruction flow.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          c_op_r:    state_d = S_EXEC_R;
          c_op_addi: state_d = S_EXEC_I;
          c_op_slti: state_d = S_EXEC_I;
          c_op_lw:   state_d = S_ADDR;
          c_op_sw:   state_d = S_ADDR;
          c_op_beq:  state_d = S_BRANCH;
          c_op_j:    state_d = S_JUMP;
          c_op_jr:   state_d = S_JR;
          c_op_jal:  state_d = S_JAL;
          default:   state_d = c_illegal_next;
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_I:   state_d = S_FETCH;
      S_ADDR:   state_d = (bus.opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) state_d = S_WB_LW;
      S_WB_LW:  state_d = S_FETCH;
      S_MEM_WR: if (bus.mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_JR:     state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Control decode from state; everything held at 0 while rst is high.
  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_src        = 2'b00;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_reg_dst       = 2'b00;
    w_write_dst     = 2'b00;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = c_alu_add;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;
    w_halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          w_mem_read  = 1'b1;
          w_alu_src_b = 2'b01;
          w_ir_write  = bus.mem_ready;
          w_pc_write  = bus.mem_ready;
        end
        S_DECODE: begin
          // Branch target is precomputed into ALUOut here.
          w_alu_src_b = 2'b11;
          if (!w_op_legal) begin
            w_illegal_op = 1'b1;
            w_instr_done = 1'b1;
          end
        end
        S_EXEC_R: begin
          w_alu_src_a = 1'b1;
          w_alu_op    = c_alu_funct;
        end
        S_WB_R: begin
          w_reg_write  = 1'b1;
          w_reg_dst    = 2'b01;
          w_instr_done = 1'b1;
        end
        S_EXEC_I: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
          w_alu_op    = (bus.opcode == c_op_slti) ? c_alu_slt : c_alu_add;
        end
        S_WB_I: begin
          w_reg_write  = 1'b1;
          w_instr_done = 1'b1;
        end
        S_ADDR: begin
          w_alu_src_a = 1'b1;
          w_alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          w_mem_read = 1'b1;
          w_i_or_d   = 1'b1;
        end
        S_WB_LW: begin
          w_reg_write  = 1'b1;
          w_write_dst  = 2'b01;
          w_instr_done = 1'b1;
        end
        S_MEM_WR: begin
          w_mem_write  = 1'b1;
          w_i_or_d     = 1'b1;
          w_instr_done = bus.mem_ready;
        end
        S_BRANCH: begin
          w_alu_src_a     = 1'b1;
          w_alu_op        = c_alu_sub;
          w_pc_write_cond = 1'b1;
          w_pc_src        = 2'b01;
          w_instr_done    = 1'b1;
        end
        S_JUMP: begin
          w_pc_write   = 1'b1;
          w_pc_src     = 2'b10;
          w_instr_done = 1'b1;
        end
        S_JR: begin
          w_pc_write   = 1'b1;
          w_pc_src     = 2'b11;
          w_instr_done = 1'b1;
        end
        S_JAL: begin
          // PC already holds PC+4, which is the link value.
          w_reg_write  = 1'b1;
          w_reg_dst    = 2'b10;
          w_write_dst  = 2'b10;
          w_pc_write   = 1'b1;
          w_pc_src     = 2'b10;
          w_instr_done = 1'b1;
        end
        S_HALT: begin
          w_halted = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.pc_src        = w_pc_src;
  assign bus.i_or_d        = w_i_or_d;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.reg_write     = w_reg_write;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.write_dst     = w_write_dst;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.instr_done    = w_instr_done;
  assign bus.illegal_op    = w_illegal_op;
  assign bus.halted        = w_halted;

`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             w_stall;

  assign w_stall = !bus.mem_ready &&
                   ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR));

  // Counter increments; both wrap naturally at all-ones.
  always_comb begin
    instr_count_d = instr_count_q + CNT_W'(w_instr_done);
    stall_count_d = stall_count_q + CNT_W'(w_stall);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      instr_count_q <= instr_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign instr_count = instr_count_q;
  assign stall_count = stall_count_q;
`else
  // Counter width only matters when the counters are built.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. Each scenario
//               queues per-cycle expected control vectors with the stimulus
//               and compares them as the controller steps. A second instance
//               built with ILLEGAL_TRAP=1 covers the HALT path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] write_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
    logic       halted;
  } ctl_t;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OPC_W(6), .ALUOP_W(3)) bus   ();
  multicycle_controller_if #(.OPC_W(6), .ALUOP_W(3)) bus_t ();

`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
  logic [31:0] instr_count, stall_count, instr_count_t, stall_count_t;
`endif

  multicycle_controller #(.OPC_W(6), .ALUOP_W(3), .ILLEGAL_TRAP(0), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
    ,
    .instr_count(instr_count),
    .stall_count(stall_count)
`endif
  );

  multicycle_controller #(.OPC_W(6), .ALUOP_W(3), .ILLEGAL_TRAP(1), .CNT_W(32)) dut_trap (
    .clk(clk),
    .rst(rst2),
    .bus(bus_t)
`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
    ,
    .instr_count(instr_count_t),
    .stall_count(stall_count_t)
`endif
  );

  ctl_t obs, obs_t;
  assign obs = {bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.reg_write, bus.reg_dst, bus.write_dst,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.instr_done, bus.illegal_op,
                bus.halted};
  assign obs_t = {bus_t.pc_write, bus_t.pc_write_cond, bus_t.pc_src, bus_t.i_or_d,
                  bus_t.mem_read, bus_t.mem_write, bus_t.ir_write, bus_t.reg_write,
                  bus_t.reg_dst, bus_t.write_dst, bus_t.alu_src_a, bus_t.alu_src_b,
                  bus_t.alu_op, bus_t.instr_done, bus_t.illegal_op, bus_t.halted};

  int   n_checks = 0;
  int   n_fail   = 0;
  ctl_t exp_q[$];
  bit   mr_q[$];

  // ---------------- expected vectors, one per controller state ------------
  function automatic ctl_t e_fetch(bit mr);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr;
    return c;
  endfunction
  function automatic ctl_t e_decode();
    ctl_t c = '0;
    c.alu_src_b = 2'b11;
    return c;
  endfunction
  function automatic ctl_t e_bad();
    ctl_t c = e_decode();
    c.illegal_op = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_exec_r();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b101;
    return c;
  endfunction
  function automatic ctl_t e_wb_r();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.reg_dst = 2'b01; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_exec_i(bit slti);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = slti ? 3'b011 : 3'b000;
    return c;
  endfunction
  function automatic ctl_t e_wb_i();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_addr();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t e_mem_rd();
    ctl_t c = '0;
    c.mem_read = 1'b1; c.i_or_d = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_wb_lw();
    ctl_t c = '0;
    c.reg_write = 1'b1; c.write_dst = 2'b01; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_mem_wr(bit mr);
    ctl_t c = '0;
    c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = mr;
    return c;
  endfunction
  function automatic ctl_t e_branch();
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 3'b001; c.pc_write_cond = 1'b1;
    c.pc_src = 2'b01; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_jump(bit [1:0] src);
    ctl_t c = '0;
    c.pc_write = 1'b1; c.pc_src = src; c.instr_done = 1'b1;
    return c;
  endfunction
  function automatic ctl_t e_jal();
    ctl_t c = e_jump(2'b10);
    c.reg_write = 1'b1; c.reg_dst = 2'b10; c.write_dst = 2'b10;
    return c;
  endfunction
  function automatic ctl_t e_halt();
    ctl_t c = '0;
    c.halted = 1'b1;
    return c;
  endfunction

  // Queue one cycle of stimulus with its expected control vector.
  task automatic plan(input bit mr, input ctl_t e);
    mr_q.push_back(mr);
    exp_q.push_back(e);
  endtask

  // Drive mem_ready for one cycle on the main DUT and sample mid-cycle.
  task automatic cycle(input bit mr, output ctl_t got);
    bus.mem_ready = mr;
    @(negedge clk);
    got = obs;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    rst = 1'b1; rst2 = 1'b1;
    bus.mem_ready = 1'b1; bus_t.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, ctl_t'('0));
    end
    n_checks++;
    if (obs_t !== '0) begin
      n_fail++; $display("FAIL reset_outputs_trap: got %h expected %h", obs_t, ctl_t'('0));
    end
    @(posedge clk); #1;
    bus_t.mem_ready = 1'b0;
    rst = 1'b0; rst2 = 1'b0;
  endtask

  task automatic test_r_type();
    ctl_t got, e;
    int cyc = 0;
    bus.opcode = 6'd0;
    plan(1, e_fetch(1)); plan(1, e_decode()); plan(1, e_exec_r()); plan(1, e_wb_r());
    while (exp_q.size() != 0) begin
      cycle(mr_q.pop_front(), got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL r_type cycle %0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_imm();
    ctl_t got, e;
    int cyc = 0;
    for (int k = 0; k < 2; k++) begin
      bus.opcode = (k == 0) ? 6'd1 : 6'd2;
      plan(1, e_fetch(1)); plan(1, e_decode()); plan(1, e_exec_i(k == 1)); plan(1, e_wb_i());
      while (exp_q.size() != 0) begin
        cycle(mr_q.pop_front(), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++; $display("FAIL imm op%0d cycle %0d: got %h expected %h", k + 1, cyc, got, e);
        end
        cyc++;
      end
    end
  endtask

  task automatic test_lw_wait();
    ctl_t got, e;
    int cyc = 0;
    bus.opcode = 6'd3;
    plan(0, e_fetch(0)); plan(0, e_fetch(0)); plan(1, e_fetch(1));
    plan(1, e_decode()); plan(1, e_addr());
    plan(0, e_mem_rd()); plan(0, e_mem_rd()); plan(0, e_mem_rd()); plan(1, e_mem_rd());
    plan(1, e_wb_lw());
    while (exp_q.size() != 0) begin
      cycle(mr_q.pop_front(), got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL lw_wait cycle %0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_sw();
    ctl_t got, e;
    int cyc = 0;
    bus.opcode = 6'd4;
    plan(1, e_fetch(1)); plan(1, e_decode()); plan(1, e_addr());
    plan(0, e_mem_wr(0)); plan(1, e_mem_wr(1));
    while (exp_q.size() != 0) begin
      cycle(mr_q.pop_front(), got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL sw cycle %0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_beq();
    ctl_t got, e;
    int cyc = 0;
    bus.opcode = 6'd5;
    for (int z = 1; z >= 0; z--) begin
      bus.zero = z[0];
      plan(1, e_fetch(1)); plan(1, e_decode()); plan(1, e_branch());
      while (exp_q.size() != 0) begin
        cycle(mr_q.pop_front(), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++; $display("FAIL beq zero=%0d cycle %0d: got %h expected %h", z, cyc, got, e);
        end
        cyc++;
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    ctl_t got, e;
    int cyc = 0;
    bit [5:0] ops [3] = '{6'd6, 6'd7, 6'd8};
    for (int k = 0; k < 3; k++) begin
      bus.opcode = ops[k];
      plan(1, e_fetch(1)); plan(1, e_decode());
      plan(1, (k == 0) ? e_jump(2'b10) : (k == 1) ? e_jump(2'b11) : e_jal());
      while (exp_q.size() != 0) begin
        cycle(mr_q.pop_front(), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++; $display("FAIL jumps op%0d cycle %0d: got %h expected %h", ops[k], cyc, got, e);
        end
        cyc++;
      end
    end
  endtask

  task automatic test_illegal();
    ctl_t got, e;
    int cyc = 0;
    bit [5:0] ops [3] = '{6'b001111, 6'b010000, 6'b001001};
    for (int k = 0; k < 3; k++) begin
      bus.opcode = ops[k];
      plan(1, e_fetch(1)); plan(1, e_bad());
      while (exp_q.size() != 0) begin
        cycle(mr_q.pop_front(), got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) begin
          n_fail++; $display("FAIL illegal op%0d cycle %0d: got %h expected %h", ops[k], cyc, got, e);
        end
        cyc++;
      end
    end
    // Must be back in FETCH: a stalled fetch cycle shows it.
    bus.opcode = 6'd0;
    plan(0, e_fetch(0));
    cycle(mr_q.pop_front(), got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL illegal_return: got %h expected %h", got, e);
    end
  endtask

  task automatic test_trap();
    ctl_t got, e;
    int cyc = 0;
    bus_t.opcode = 6'b001111;
    bus_t.mem_ready = 1'b1;
    exp_q.push_back(e_fetch(1)); exp_q.push_back(e_bad());
    exp_q.push_back(e_halt()); exp_q.push_back(e_halt()); exp_q.push_back(e_halt());
    while (exp_q.size() != 0) begin
      @(negedge clk);
      got = obs_t;
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL trap cycle %0d: got %h expected %h", cyc, got, e);
      end
      @(posedge clk); #1;
      cyc++;
    end
    rst2 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs_t !== '0) begin
      n_fail++; $display("FAIL trap_reset: got %h expected %h", obs_t, ctl_t'('0));
    end
    @(posedge clk); #1;
    rst2 = 1'b0;
    bus_t.mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs_t !== e_fetch(0)) begin
      n_fail++; $display("FAIL trap_after_reset: got %h expected %h", obs_t, e_fetch(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    ctl_t got, e;
    int cyc = 0;
    bus.opcode = 6'd4;
    plan(1, e_fetch(1)); plan(1, e_decode()); plan(1, e_addr()); plan(0, e_mem_wr(0));
    while (exp_q.size() != 0) begin
      cycle(mr_q.pop_front(), got);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL reset_mid cycle %0d: got %h expected %h", cyc, got, e);
      end
      cyc++;
    end
    // Still in MEM_WR waiting; reset now must kill mem_write immediately.
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== '0) begin
      n_fail++; $display("FAIL reset_mid_strobes: got %h expected %h", obs, ctl_t'('0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    plan(0, e_fetch(0));
    cycle(mr_q.pop_front(), got);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset_mid_fetch: got %h expected %h", got, e);
    end
  endtask

`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
  task automatic test_perf_cnt();
    ctl_t got;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (instr_count !== 32'd0 || stall_count !== 32'd0) begin
      n_fail++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", instr_count, stall_count);
    end
    bus.opcode = 6'd6;
    for (int k = 0; k < 9; k++) cycle(1'b1, got);
    n_checks++;
    if (instr_count !== 32'd3 || stall_count !== 32'd0) begin
      n_fail++; $display("FAIL perf_3j: got %0d/%0d expected 3/0", instr_count, stall_count);
    end
    // lw with 2 fetch stalls and 3 memory stalls
    bus.opcode = 6'd3;
    cycle(0, got); cycle(0, got); cycle(1, got); cycle(1, got); cycle(1, got);
    cycle(0, got); cycle(0, got); cycle(0, got); cycle(1, got); cycle(1, got);
    n_checks++;
    if (instr_count !== 32'd4 || stall_count !== 32'd5) begin
      n_fail++; $display("FAIL perf_lw: got %0d/%0d expected 4/5", instr_count, stall_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    bus_t.opcode = '0; bus_t.zero = 1'b0; bus_t.mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_imm();
    test_lw_wait();
    test_sw();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_trap();
    test_reset_mid();
`ifdef MULTICYCLE_CONTROLLER_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
